// File: rtl/stv_elastic_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : stv_elastic_buffer
//  Purpose  : Parameterisable elastic (FIFO) buffer with valid/ready on both
//             sides. Every output comes straight from flops: ready_out,
//             valid_out, count and almost_full are registered. data_out is the
//             storage entry chosen by the registered read pointer. Data written
//             at edge N is visible with valid_out=1 right after edge N; there is
//             no empty bypass. With DEPTH=2 it behaves like a 2-entry skid
//             buffer cycle for cycle.
//
//  Ports    : clk         - single clock, rising edge
//             arst        - asynchronous active-high reset
//             valid_in    - initiator data valid
//             ready_out   - buffer can accept data (registered)
//             data_in     - initiator data, WIDTH bits
//             ready_in    - target ready
//             valid_out   - buffer holds data for the target (registered)
//             data_out    - head-of-buffer data, WIDTH bits
//             flush       - synchronous discard of all contents
//             count       - current occupancy, $clog2(DEPTH+1) bits
//             almost_full - count >= AF_LEVEL (registered)
//
//  Revision : 1.0 - initial release
// ============================================================================
module stv_elastic_buffer #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       valid_in,
    output logic                       ready_out,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       ready_in,
    output logic                       valid_out,
    output logic [WIDTH-1:0]           data_out,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                 c_PTR_W    = $clog2(DEPTH);
    localparam int                 c_CNT_W    = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_AF_CNT   = c_CNT_W'(AF_LEVEL);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(DEPTH - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam bit                 c_IS_POW2  = ((DEPTH & (DEPTH - 1)) == 0);

    // ------------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_valid;
    logic               r_ready;
    logic               r_af;

    logic [c_PTR_W-1:0] w_wr_ptr_inc;
    logic [c_PTR_W-1:0] w_rd_ptr_inc;
    logic [c_PTR_W-1:0] w_wr_ptr_nxt;
    logic [c_PTR_W-1:0] w_rd_ptr_nxt;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic               w_push;
    logic               w_pop;

    // Handshakes use only the registered flags, so no input reaches an output
    // combinationally. Flush cancels both handshakes in its cycle.
    assign w_push = valid_in & r_ready & ~flush;
    assign w_pop  = r_valid  & ready_in & ~flush;

    // ------------------------------------------------------------------------
    // Pointer increment: a power-of-two depth wraps naturally, any other depth
    // needs an explicit wrap from DEPTH-1 back to 0.
    // ------------------------------------------------------------------------
    generate
        if (c_IS_POW2) begin : g_ptr_pow2
            assign w_wr_ptr_inc = r_wr_ptr + c_PTR_ONE;
            assign w_rd_ptr_inc = r_rd_ptr + c_PTR_ONE;
        end else begin : g_ptr_wrap
            assign w_wr_ptr_inc = (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + c_PTR_ONE;
            assign w_rd_ptr_inc = (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + c_PTR_ONE;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Next-state computation
    // ------------------------------------------------------------------------
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        if (flush) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_count_nxt  = '0;
        end else begin
            if (w_push) begin
                w_wr_ptr_nxt = w_wr_ptr_inc;
            end
            if (w_pop) begin
                w_rd_ptr_nxt = w_rd_ptr_inc;
            end
            // Simultaneous push and pop leaves the occupancy unchanged. Push
            // needs r_ready (count < DEPTH) and pop needs r_valid (count != 0),
            // so neither step can leave the 0..DEPTH range.
            unique case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + c_CNT_W'(1);
                2'b01:   w_count_nxt = r_count - c_CNT_W'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Control registers. The flags are computed from the next count so that
    // they always agree with the count register in the same cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_ready  <= 1'b1;
            r_af     <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_valid  <= (w_count_nxt != '0);
            r_ready  <= (w_count_nxt < c_FULL_CNT);
            r_af     <= (w_count_nxt >= c_AF_CNT);
        end
    end

    // ------------------------------------------------------------------------
    // Storage array: no reset and untouched by flush; only the pointers and
    // the occupancy decide what is valid.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ready_out   = r_ready;
    assign valid_out   = r_valid;
    assign count       = r_count;
    assign almost_full = r_af;
    // The read pointer is a register, so the head entry is stable while the
    // target applies backpressure. When empty it shows a stale entry.
    assign data_out    = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_stv_elastic_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stv_elastic_buffer
//  Purpose  : Self-checking bench for stv_elastic_buffer. Four instances with
//             DEPTH 4, 3, 2 and 5 share clock and reset; each scenario drives
//             one instance. Accepted input beats go to an expected queue, beats
//             taken by the target go to an observed queue, and the scenarios
//             compare the two together with occupancy against a count model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stv_elastic_buffer;

    function automatic int dep(input int k);
        return (k == 0) ? 4 : (k == 1) ? 3 : (k == 2) ? 2 : 5;
    endfunction

    logic            clk = 1'b0;
    logic            arst;
    logic [3:0]      r_vin;
    logic [3:0]      r_rin;
    logic [3:0]      r_fl;
    logic [3:0][7:0] r_din;
    wire  [3:0]      w_rout;
    wire  [3:0]      w_vout;
    wire  [3:0]      w_af;
    wire  [3:0][7:0] w_dout;
    wire  [3:0][3:0] w_cnt;

    int         n_vec = 0;
    int         n_err = 0;
    int         m_cnt = 0;
    logic [7:0] exp_q [$];
    logic [7:0] obs_q [$];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        localparam int D = dep(gi);
        wire [$clog2(D+1)-1:0] w_c;
        stv_elastic_buffer #(.WIDTH(8), .DEPTH(D)) u_dut (
            .clk        (clk),
            .arst       (arst),
            .valid_in   (r_vin[gi]),
            .ready_out  (w_rout[gi]),
            .data_in    (r_din[gi]),
            .ready_in   (r_rin[gi]),
            .valid_out  (w_vout[gi]),
            .data_out   (w_dout[gi]),
            .flush      (r_fl[gi]),
            .count      (w_c),
            .almost_full(w_af[gi])
        );
        assign w_cnt[gi] = 4'(w_c);
    end

    // Advance one clock on instance k: record accepted and delivered beats
    // from the values present before the edge, update the count model, then
    // land 1 time unit after the edge.
    task automatic tick(input int k);
        logic push;
        logic pop;
        push = r_vin[k] && w_rout[k] && !r_fl[k];
        pop  = w_vout[k] && r_rin[k] && !r_fl[k];
        if (r_fl[k]) begin
            m_cnt = 0;
            exp_q.delete();
        end else begin
            if (push) exp_q.push_back(r_din[k]);
            if (pop)  obs_q.push_back(w_dout[k]);
            m_cnt = m_cnt + int'(push) - int'(pop);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arst  = 1'b1;
        r_vin = '0;
        r_rin = '0;
        r_fl  = '0;
        r_din = '0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if ({w_cnt[k], w_vout[k], w_rout[k], w_af[k]} !== {4'd0, 1'b0, 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL reset[%0d]: got cnt=%0d v=%b r=%b af=%b, need cnt=0 v=0 r=1 af=0", k, w_cnt[k], w_vout[k], w_rout[k], w_af[k]);
            end
        end
        arst = 1'b0;
    endtask

    // DEPTH=4: four pushes under backpressure, then a fifth beat is refused.
    task automatic test_fill();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        m_cnt = 0;
        r_rin[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            r_vin[0] = 1'b1;
            r_din[0] = vals[i];
            tick(0);
            n_vec++;
            if ({w_cnt[0], w_vout[0], w_rout[0], w_af[0]} !== {4'(i + 1), 1'b1, (i + 1) < 4, (i + 1) >= 3}) begin
                n_err++;
                $display("FAIL fill beat %0d: got cnt=%0d v=%b r=%b af=%b, need cnt=%0d v=1 r=%b af=%b", i, w_cnt[0], w_vout[0], w_rout[0], w_af[0], i + 1, (i + 1) < 4, (i + 1) >= 3);
            end
        end
        r_din[0] = 8'h55;
        tick(0);
        n_vec++;
        if ({w_cnt[0], w_rout[0]} !== {4'd4, 1'b0}) begin
            n_err++;
            $display("FAIL fill 5th beat: got cnt=%0d r=%b, need cnt=4 r=0", w_cnt[0], w_rout[0]);
        end
        r_vin[0] = 1'b0;
    endtask

    // From full: four pops in order, then empty.
    task automatic test_drain();
        logic [7:0] got;
        logic [7:0] want;
        r_rin[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(0);
            n_vec++;
            if ({w_cnt[0], w_vout[0], w_rout[0], w_af[0]} !== {4'(m_cnt), m_cnt != 0, m_cnt < 4, m_cnt >= 3}) begin
                n_err++;
                $display("FAIL drain step %0d: got cnt=%0d v=%b r=%b af=%b, need cnt=%0d", i, w_cnt[0], w_vout[0], w_rout[0], w_af[0], m_cnt);
            end
        end
        r_rin[0] = 1'b0;
        n_vec++;
        if (obs_q.size() !== 4 || exp_q.size() !== 4) begin
            n_err++;
            $display("FAIL drain beats: got %0d delivered, need 4", obs_q.size());
        end
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            got  = obs_q.pop_front();
            want = exp_q.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL drain data: got %h, need %h", got, want);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    // DEPTH=3: ten streamed beats, pointers wrap several times.
    task automatic test_wrap();
        logic [7:0] got;
        logic [7:0] want;
        m_cnt = 0;
        r_rin[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            r_vin[1] = 1'b1;
            r_din[1] = 8'(8'h60 + i);
            tick(1);
            n_vec++;
            if ({w_cnt[1], w_vout[1], w_rout[1]} !== {4'd1, 1'b1, 1'b1}) begin
                n_err++;
                $display("FAIL wrap beat %0d: got cnt=%0d v=%b r=%b, need cnt=1 v=1 r=1", i, w_cnt[1], w_vout[1], w_rout[1]);
            end
        end
        r_vin[1] = 1'b0;
        tick(1);
        r_rin[1] = 1'b0;
        n_vec++;
        if ({w_cnt[1], w_vout[1], 4'(obs_q.size())} !== {4'd0, 1'b0, 4'd10}) begin
            n_err++;
            $display("FAIL wrap end: got cnt=%0d v=%b delivered=%0d, need cnt=0 v=0 delivered=10", w_cnt[1], w_vout[1], obs_q.size());
        end
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            got  = obs_q.pop_front();
            want = exp_q.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL wrap data: got %h, need %h", got, want);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    // DEPTH=4: flush at count 2 with push and pop presented together.
    task automatic test_flush();
        logic [7:0] got;
        logic [7:0] want;
        m_cnt = 0;
        r_rin[0] = 1'b0;
        r_vin[0] = 1'b1;
        r_din[0] = 8'hB1;
        tick(0);
        r_din[0] = 8'hB2;
        tick(0);
        n_vec++;
        if (w_cnt[0] !== 4'd2) begin
            n_err++;
            $display("FAIL flush setup: got cnt=%0d, need 2", w_cnt[0]);
        end
        r_fl[0]  = 1'b1;
        r_rin[0] = 1'b1;
        r_din[0] = 8'hBF;
        tick(0);
        r_fl[0] = 1'b0;
        n_vec++;
        if ({w_cnt[0], w_vout[0], w_rout[0], w_af[0], 4'(obs_q.size())} !== {4'd0, 1'b0, 1'b1, 1'b0, 4'd0}) begin
            n_err++;
            $display("FAIL flush: got cnt=%0d v=%b r=%b af=%b delivered=%0d, need cnt=0 v=0 r=1 af=0 delivered=0", w_cnt[0], w_vout[0], w_rout[0], w_af[0], obs_q.size());
        end
        r_din[0] = 8'hC3;
        tick(0);
        r_vin[0] = 1'b0;
        tick(0);
        tick(0);
        r_rin[0] = 1'b0;
        n_vec++;
        if ({w_cnt[0], w_vout[0], 4'(obs_q.size())} !== {4'd0, 1'b0, 4'd1}) begin
            n_err++;
            $display("FAIL flush after: got cnt=%0d v=%b delivered=%0d, need cnt=0 v=0 delivered=1", w_cnt[0], w_vout[0], obs_q.size());
        end
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            got  = obs_q.pop_front();
            want = exp_q.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL flush data: got %h, need %h", got, want);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    // DEPTH=5: async reset pulse between edges at count 3.
    task automatic test_async_reset();
        logic [7:0] got;
        m_cnt = 0;
        r_rin[3] = 1'b0;
        r_vin[3] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            r_din[3] = 8'(8'hD1 + i);
            tick(3);
        end
        r_vin[3] = 1'b0;
        n_vec++;
        if (w_cnt[3] !== 4'd3) begin
            n_err++;
            $display("FAIL arst setup: got cnt=%0d, need 3", w_cnt[3]);
        end
        #2 arst = 1'b1;
        #1;
        n_vec++;
        if ({w_cnt[3], w_vout[3], w_rout[3], w_af[3]} !== {4'd0, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL arst immediate: got cnt=%0d v=%b r=%b af=%b, need cnt=0 v=0 r=1 af=0", w_cnt[3], w_vout[3], w_rout[3], w_af[3]);
        end
        #2 arst = 1'b0;
        m_cnt = 0;
        exp_q.delete();
        obs_q.delete();
        r_vin[3] = 1'b1;
        r_din[3] = 8'hA5;
        tick(3);
        r_vin[3] = 1'b0;
        n_vec++;
        if ({w_cnt[3], w_vout[3]} !== {4'd1, 1'b1}) begin
            n_err++;
            $display("FAIL arst push: got cnt=%0d v=%b, need cnt=1 v=1", w_cnt[3], w_vout[3]);
        end
        r_rin[3] = 1'b1;
        tick(3);
        r_rin[3] = 1'b0;
        got = (obs_q.size() != 0) ? obs_q.pop_front() : 8'hxx;
        n_vec++;
        if (got !== 8'hA5) begin
            n_err++;
            $display("FAIL arst data: got %h, need a5", got);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    // Random traffic on instance k; checks order, stability and occupancy.
    task automatic test_random(input int k, input int cycles);
        logic       hold;
        logic [7:0] hd;
        logic [7:0] got;
        logic [7:0] want;
        int         d;
        int         pv;
        int         pr;
        d = dep(k);
        m_cnt = 0;
        for (int c = 0; c < cycles + d + 2; c++) begin
            if (c < cycles) begin
                case ((c / 256) % 3)
                    0:       begin pv = 3; pr = 1; end
                    1:       begin pv = 1; pr = 3; end
                    default: begin pv = 2; pr = 2; end
                endcase
                r_vin[k] = ($urandom_range(0, 3) < pv);
                r_rin[k] = ($urandom_range(0, 3) < pr);
                r_din[k] = 8'($urandom);
            end else begin
                r_vin[k] = 1'b0;
                r_rin[k] = 1'b1;
            end
            hold = w_vout[k] && !r_rin[k];
            hd   = w_dout[k];
            tick(k);
            if (hold) begin
                n_vec++;
                if ({w_vout[k], w_dout[k]} !== {1'b1, hd}) begin
                    n_err++;
                    $display("FAIL rnd[%0d] stall cyc %0d: got v=%b d=%h, need v=1 d=%h", d, c, w_vout[k], w_dout[k], hd);
                end
            end
            n_vec++;
            if ({w_cnt[k], w_vout[k], w_rout[k], w_af[k]} !== {4'(m_cnt), m_cnt != 0, m_cnt < d, m_cnt >= d - 1}) begin
                n_err++;
                $display("FAIL rnd[%0d] state cyc %0d: got cnt=%0d v=%b r=%b af=%b, need cnt=%0d", d, c, w_cnt[k], w_vout[k], w_rout[k], w_af[k], m_cnt);
            end
            while (obs_q.size() != 0) begin
                got = obs_q.pop_front();
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rnd[%0d] data cyc %0d: got %h, need nothing", d, c, got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_err++;
                        $display("FAIL rnd[%0d] data cyc %0d: got %h, need %h", d, c, got, want);
                    end
                end
            end
        end
        r_rin[k] = 1'b0;
        n_vec++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL rnd[%0d] leftover: got %0d undelivered, need 0", d, exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_flush();
        test_async_reset();
        test_random(2, 10000);
        test_random(0, 10000);
        test_random(3, 10000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/stv_elastic_buffer.md
STV_ELASTIC_BUFFER -- requirements
Module: stv_elastic_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the data width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 4, which sets the number of storage entries (>=2); any integer value is legal, power of two not required.
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-1, which sets the almost-full threshold (1..DEPTH).
REQ-004 The block SHALL have a port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have a port arst, input, 1 bit: asynchronous active-high reset.
REQ-006 The block SHALL have a port valid_in, input, 1 bit: initiator data valid.
REQ-007 The block SHALL have a port ready_out, output, 1 bit: buffer can accept data.
REQ-008 The block SHALL have a port data_in, input, WIDTH bits: initiator data.
REQ-009 The block SHALL have a port ready_in, input, 1 bit: target ready.
REQ-010 The block SHALL have a port valid_out, output, 1 bit: buffer holds data for the target.
REQ-011 The block SHALL have a port data_out, output, WIDTH bits: head-of-buffer data.
REQ-012 The block SHALL have a port flush, input, 1 bit: synchronous discard of all contents.
REQ-013 The block SHALL have a port count, output, $clog2(DEPTH+1) bits: current occupancy.
REQ-014 The block SHALL have a port almost_full, output, 1 bit: count >= AF_LEVEL.

Function
REQ-015 Push SHALL occur when valid_in && ready_out; pop SHALL occur when valid_out && ready_in.
REQ-016 Every output SHALL be driven directly from flops, with no combinational path from any input to any output.
REQ-017 ready_out SHALL be registered and equal (count < DEPTH) for the current cycle's state.
REQ-018 valid_out SHALL be registered and equal (count != 0).
REQ-019 Storage SHALL be a DEPTH-entry circular array with write and read pointers.
REQ-020 Each pointer SHALL increment by 1 on its event and wrap from DEPTH-1 to 0.
REQ-021 data_out SHALL be the entry at the read pointer, selected by a registered pointer.
REQ-022 Latency SHALL be exactly 1 cycle: data pushed at edge N is presented with valid_out=1 after edge N; there is no empty bypass.
REQ-023 Throughput SHALL be 1 transfer/cycle sustained while 0 < count < DEPTH; with DEPTH=2 the block is cycle-equivalent to the existing 2-entry skid buffer.
REQ-024 On simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-025 When full (count=DEPTH), ready_out SHALL be 0; a pop while full SHALL raise ready_out at the next edge.
REQ-026 While valid_out=1 and ready_in=0, data_out and valid_out SHALL remain stable.
REQ-027 When empty, data_out SHALL hold its previous value and SHALL NOT be relied upon.
REQ-028 count SHALL update as count + push - pop, and SHALL never exceed DEPTH or underflow.
REQ-029 almost_full SHALL be registered and consistent with count in the same cycle.
REQ-030 flush=1 SHALL, at the next edge, force count=0, pointers=0, valid_out=0, ready_out=1 and almost_full=0 (or 1 if AF_LEVEL=0 is ever permitted; it is not).
REQ-031 Flush SHALL have priority: a push or pop presented in the flush cycle SHALL be discarded, and the handshake is not considered completed.
REQ-032 Storage contents SHALL NOT be cleared by flush.

Reset
REQ-033 While arst=1, the block SHALL hold valid_out=0, ready_out=1, count=0, almost_full=0 and both pointers at 0, all asynchronously.
REQ-034 Storage and data_out SHALL NOT be reset.
REQ-035 Reset asserted mid-operation SHALL drop all contents, and the first cycle after deassertion SHALL behave as empty.

Verification
REQ-036 The bench SHALL cover this scenario: DEPTH=4, push 0x11,0x22,0x33,0x44 with ready_in=0 -> count 1,2,3,4; almost_full=1 from count=3; ready_out=0 at count=4; the 5th valid_in beat is not accepted.
REQ-037 The bench SHALL cover this scenario: from full, ready_in=1 for 4 cycles, valid_in=0 -> data_out 0x11,0x22,0x33,0x44 in order, then valid_out=0 and count=0.
REQ-038 The bench SHALL cover this scenario: DEPTH=3, 10 consecutive pushes with ready_in=1 -> valid_out 1 cycle after the first push; 10 back-to-back pops in order; pointers wrap 2->0 with no loss; count stays 1.
REQ-039 The bench SHALL cover this scenario: count=2, flush=1 together with valid_in=1 and ready_in=1 -> next cycle count=0, valid_out=0, ready_out=1; the pushed beat never appears.
REQ-040 The bench SHALL cover this scenario: count=3, arst pulsed asynchronously between edges -> valid_out=0 and count=0 immediately; after release a push of 0xA5 appears 1 cycle later.
REQ-041 The bench SHALL cover this scenario: random valid_in/ready_in for 10k cycles at DEPTH 2, 4 and 5 -> output stream equals the accepted input stream; data_out is stable under backpressure; count matches a reference model.
